// File: rtl/square_plotter.sv
// Square plotter: walks a SIZE x SIZE pixel block row-major, one pixel per cycle,
// gating the VGA write strobe for off-screen and (optionally) interior pixels.
module square_plotter #(
  parameter int SIZE = 4,
  parameter int XMAX = 160,
  parameter int YMAX = 120
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ld,
  input  logic [7:0] x_in,
  input  logic [6:0] y_in,
  input  logic [2:0] colour_in,
  input  logic       outline,
  output logic [7:0] X,
  output logic [6:0] Y,
  output logic [2:0] Colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DRAW = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] LAST = 4'(SIZE - 1);
  localparam logic [8:0] XLIM = 9'(XMAX);
  localparam logic [7:0] YLIM = 8'(YMAX);

  logic [1:0] state_q, state_d;
  logic [3:0] cx_q, cx_d;
  logic [3:0] cy_q, cy_d;
  logic [7:0] x_lat_q, x_lat_d;
  logic [6:0] y_lat_q, y_lat_d;
  logic [2:0] col_q, col_d;
  logic       outl_q, outl_d;

  logic [8:0] x_sum;
  logic [7:0] y_sum;
  logic       edge_ok;

  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    x_lat_d = x_lat_q;
    y_lat_d = y_lat_q;
    col_d   = col_q;
    outl_d  = outl_q;
    unique case (state_q)
      S_IDLE: begin
        if (ld) begin
          x_lat_d = x_in;
          y_lat_d = y_in;
          col_d   = colour_in;
          outl_d  = outline;
          cx_d    = 4'd0;
          cy_d    = 4'd0;
          state_d = S_DRAW;
        end
      end
      S_DRAW: begin
        if (cx_q == LAST) begin
          cx_d = 4'd0;
          if (cy_q == LAST) begin
            cy_d    = 4'd0;
            state_d = S_DONE;
          end else begin
            cy_d = cy_q + 4'd1;
          end
        end else begin
          cx_d = cx_q + 4'd1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cx_q    <= 4'd0;
      cy_q    <= 4'd0;
      x_lat_q <= 8'd0;
      y_lat_q <= 7'd0;
      col_q   <= 3'd0;
      outl_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      x_lat_q <= x_lat_d;
      y_lat_q <= y_lat_d;
      col_q   <= col_d;
      outl_q  <= outl_d;
    end
  end

  // Wide sums so a square hanging past 255/127 reads as off-screen, not wrapped.
  always_comb begin
    x_sum   = {1'b0, x_lat_q} + {5'd0, cx_q};
    y_sum   = {1'b0, y_lat_q} + {4'd0, cy_q};
    edge_ok = !outl_q || (cx_q == 4'd0) || (cx_q == LAST)
              || (cy_q == 4'd0) || (cy_q == LAST);
  end

  assign X      = x_sum[7:0];
  assign Y      = y_sum[6:0];
  assign Colour = col_q;
  assign plot   = (state_q == S_DRAW) && (x_sum < XLIM)
                  && (y_sum < YLIM) && edge_ok;
  assign busy   = (state_q == S_DRAW) || (state_q == S_DONE);
  assign done   = (state_q == S_DONE);

endmodule

// File: tb/tb_square_plotter.sv
// Directed bench for square_plotter: SIZE=4, 8 and 1 instances share stimulus,
// each scenario checks pixel stream, strobe timing and completion pulse.
module tb_square_plotter;

  logic       clock;
  logic       reset;
  logic       ld;
  logic [7:0] x_in;
  logic [6:0] y_in;
  logic [2:0] colour_in;
  logic       outline;

  logic [7:0] o4_x, o8_x, o1_x;
  logic [6:0] o4_y, o8_y, o1_y;
  logic [2:0] o4_c, o8_c, o1_c;
  logic       o4_p, o8_p, o1_p;
  logic       o4_b, o8_b, o1_b;
  logic       o4_d, o8_d, o1_d;

  int n_chk;
  int n_err;

  int px_x[$];
  int px_y[$];
  int px_c[$];
  int px_k[$];
  int busy_low;

  square_plotter #(.SIZE(4)) u_dut (
    .clock(clock), .reset(reset), .ld(ld), .x_in(x_in), .y_in(y_in),
    .colour_in(colour_in), .outline(outline), .X(o4_x), .Y(o4_y),
    .Colour(o4_c), .plot(o4_p), .busy(o4_b), .done(o4_d)
  );

  square_plotter #(.SIZE(8)) u_d8 (
    .clock(clock), .reset(reset), .ld(ld), .x_in(x_in), .y_in(y_in),
    .colour_in(colour_in), .outline(outline), .X(o8_x), .Y(o8_y),
    .Colour(o8_c), .plot(o8_p), .busy(o8_b), .done(o8_d)
  );

  square_plotter #(.SIZE(1)) u_d1 (
    .clock(clock), .reset(reset), .ld(ld), .x_in(x_in), .y_in(y_in),
    .colour_in(colour_in), .outline(outline), .X(o1_x), .Y(o1_y),
    .Colour(o1_c), .plot(o1_p), .busy(o1_b), .done(o1_d)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    ld    = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic start(input logic [7:0] x, input logic [6:0] y,
                       input logic [2:0] c, input logic o);
    @(negedge clock);
    x_in      = x;
    y_in      = y;
    colour_in = c;
    outline   = o;
    ld        = 1'b1;
  endtask

  task automatic capture(input int sel, input int maxc, input int inj,
                         output int dcyc);
    logic [7:0] vx;
    logic [6:0] vy;
    logic [2:0] vc;
    logic       vp, vb, vd;
    px_x.delete();
    px_y.delete();
    px_c.delete();
    px_k.delete();
    busy_low = 0;
    dcyc = -1;
    for (int k = 1; k <= maxc; k++) begin
      @(negedge clock);
      if (k == 1) ld = 1'b0;
      if (k == inj) begin
        ld        = 1'b1;
        x_in      = 8'd100;
        y_in      = 7'd50;
        colour_in = 3'd6;
        outline   = 1'b1;
      end
      if (k == inj + 1) ld = 1'b0;
      case (sel)
        1: begin
          vx = o8_x; vy = o8_y; vc = o8_c; vp = o8_p; vb = o8_b; vd = o8_d;
        end
        2: begin
          vx = o1_x; vy = o1_y; vc = o1_c; vp = o1_p; vb = o1_b; vd = o1_d;
        end
        default: begin
          vx = o4_x; vy = o4_y; vc = o4_c; vp = o4_p; vb = o4_b; vd = o4_d;
        end
      endcase
      if (!vb) busy_low++;
      if (vp) begin
        px_x.push_back(int'(vx));
        px_y.push_back(int'(vy));
        px_c.push_back(int'(vc));
        px_k.push_back(k);
      end
      if (vd) begin
        dcyc = k;
        break;
      end
    end
  endtask

  initial begin
    int dc;
    int errs;
    int cnt;
    n_chk     = 0;
    n_err     = 0;
    reset     = 1'b1;
    ld        = 1'b0;
    x_in      = 8'd0;
    y_in      = 7'd0;
    colour_in = 3'd0;
    outline   = 1'b0;

    // reset state, during and one cycle after reset
    @(negedge clock);
    @(negedge clock);
    chk("rst_x", int'(o4_x), 0);
    chk("rst_plot", int'(o4_p), 0);
    chk("rst_busy", int'(o4_b), 0);
    reset = 1'b0;
    @(negedge clock);
    chk("rst1_x", int'(o4_x), 0);
    chk("rst1_y", int'(o4_y), 0);
    chk("rst1_col", int'(o4_c), 0);
    chk("rst1_plot", int'(o4_p), 0);
    chk("rst1_busy", int'(o4_b), 0);
    chk("rst1_done", int'(o4_d), 0);

    // filled 4x4 at (10,20), colour 4
    start(8'd10, 7'd20, 3'd4, 1'b0);
    capture(0, 40, 0, dc);
    chk("fill_done_cyc", dc, 17);
    chk("fill_nplot", px_x.size(), 16);
    chk("fill_busy_low", busy_low, 0);
    if (px_x.size() == 16) begin
      chk("fill_first_x", px_x[0], 10);
      chk("fill_first_y", px_y[0], 20);
      chk("fill_last_x", px_x[15], 13);
      chk("fill_last_y", px_y[15], 23);
      chk("fill_first_k", px_k[0], 1);
      chk("fill_last_k", px_k[15], 16);
      errs = 0;
      for (int i = 0; i < 16; i++) begin
        if (px_x[i] != 10 + i % 4 || px_y[i] != 20 + i / 4) errs++;
        if (px_c[i] != 4) errs++;
      end
      chk("fill_order_col", errs, 0);
    end

    // bottom-right corner clipping
    do_reset();
    start(8'd158, 7'd118, 3'd1, 1'b0);
    capture(0, 40, 0, dc);
    chk("clip_done_cyc", dc, 17);
    chk("clip_nplot", px_x.size(), 4);
    if (px_x.size() == 4) begin
      errs = 0;
      if (px_x[0] != 158 || px_y[0] != 118) errs++;
      if (px_x[1] != 159 || px_y[1] != 118) errs++;
      if (px_x[2] != 158 || px_y[2] != 119) errs++;
      if (px_x[3] != 159 || px_y[3] != 119) errs++;
      chk("clip_pixels", errs, 0);
    end

    // outline at origin: 12 border pixels, no interior
    do_reset();
    start(8'd0, 7'd0, 3'd2, 1'b1);
    capture(0, 40, 0, dc);
    chk("outl_done_cyc", dc, 17);
    chk("outl_nplot", px_x.size(), 12);
    cnt = 0;
    foreach (px_x[i])
      if (px_x[i] >= 1 && px_x[i] <= 2 && px_y[i] >= 1 && px_y[i] <= 2)
        cnt++;
    chk("outl_interior", cnt, 0);

    // ld during draw ignored, back-to-back after done
    do_reset();
    start(8'd30, 7'd40, 3'd2, 1'b0);
    capture(0, 40, 5, dc);
    chk("ign_done_cyc", dc, 17);
    chk("ign_nplot", px_x.size(), 16);
    if (px_x.size() == 16) begin
      errs = 0;
      for (int i = 0; i < 16; i++) begin
        if (px_x[i] != 30 + i % 4 || px_y[i] != 40 + i / 4) errs++;
        if (px_c[i] != 2) errs++;
      end
      chk("ign_pixels", errs, 0);
    end
    @(negedge clock);
    chk("gap_busy", int'(o4_b), 0);
    x_in      = 8'd100;
    y_in      = 7'd50;
    colour_in = 3'd6;
    outline   = 1'b0;
    ld        = 1'b1;
    capture(0, 40, 0, dc);
    chk("b2b_done_cyc", dc, 17);
    chk("b2b_nplot", px_x.size(), 16);
    if (px_x.size() > 0) begin
      chk("b2b_first_x", px_x[0], 100);
      chk("b2b_first_y", px_y[0], 50);
      chk("b2b_col", px_c[0], 6);
      chk("b2b_first_k", px_k[0], 1);
    end

    // reset in mid-draw aborts the square
    do_reset();
    start(8'd10, 7'd10, 3'd5, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clock);
      if (k == 1) ld = 1'b0;
    end
    chk("abort_busy_pre", int'(o4_b), 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort_plot", int'(o4_p), 0);
    chk("abort_busy", int'(o4_b), 0);
    chk("abort_done", int'(o4_d), 0);
    chk("abort_x", int'(o4_x), 0);
    chk("abort_col", int'(o4_c), 0);
    cnt = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clock);
      if (o4_p || o4_d || o4_b) cnt++;
    end
    chk("abort_quiet", cnt, 0);
    start(8'd20, 7'd30, 3'd3, 1'b0);
    capture(0, 40, 0, dc);
    chk("post_abort_done", dc, 17);
    chk("post_abort_nplot", px_x.size(), 16);

    // reset wins over ld in the same cycle
    @(negedge clock);
    reset     = 1'b1;
    ld        = 1'b1;
    x_in      = 8'd77;
    y_in      = 7'd33;
    colour_in = 3'd7;
    @(negedge clock);
    reset = 1'b0;
    ld    = 1'b0;
    chk("prio_busy", int'(o4_b), 0);
    chk("prio_x", int'(o4_x), 0);
    @(negedge clock);
    chk("prio_busy2", int'(o4_b), 0);

    // SIZE=8 wrapping past 255: nothing on-screen, done still pulses
    do_reset();
    start(8'd250, 7'd0, 3'd1, 1'b0);
    capture(1, 100, 0, dc);
    chk("wrap_done_cyc", dc, 65);
    chk("wrap_nplot", px_x.size(), 0);

    // SIZE=1 with outline: single pixel plotted
    do_reset();
    start(8'd5, 7'd6, 3'd7, 1'b1);
    capture(2, 20, 0, dc);
    chk("one_done_cyc", dc, 2);
    chk("one_nplot", px_x.size(), 1);
    if (px_x.size() == 1) begin
      chk("one_x", px_x[0], 5);
      chk("one_y", px_y[0], 6);
      chk("one_col", px_c[0], 7);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
